// File: rtl/bin_ser_pkg.sv
// Shared HOG histogram definitions: bin count, index width and bin width
// derivation, used by both the histogram producer and the bin serializer.
package bin_ser_pkg;

  localparam int unsigned NBINS = 9;
  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int unsigned bin_width(input int unsigned bin_i, input int unsigned mag_f);
    return bin_i + mag_f;
  endfunction

endpackage

// File: rtl/bin_ser_fifo.sv
// Two-entry histogram store with read/write pointers and occupancy count.
// Entry contents are not reset; only the pointers and count are.
module bin_ser_fifo
  import bin_ser_pkg::*;
#(
  parameter int unsigned BIN_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [BIN_W*NBINS-1:0] din_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [BIN_W-1:0]       head_o,
  output logic [1:0]             count_o
);

  logic [NBINS-1:0][BIN_W-1:0] mem_q [2];
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0]                  count_q, count_d;

  // Storage write; caller guarantees push_i only when an entry is free
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q][rd_idx_i];
  assign count_o = count_q;

endmodule

// File: rtl/bin_ser.sv
// Serializes packed 9-bin HOG histograms into one bin per word with a
// 2-deep histogram buffer; overflowing histograms are dropped and flagged.
module bin_ser
  import bin_ser_pkg::*;
#(
  parameter  int unsigned BIN_I = 16,
  parameter  int unsigned MAG_F = 4,
  localparam int unsigned BIN_W = bin_width(BIN_I, MAG_F)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [BIN_W*NBINS-1:0] bin,
  output logic                   i_ready,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [BIN_W-1:0]       o_bin,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_last,
  output logic                   ovf
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         count_s;
  logic [BIN_W-1:0]   head_s;
  logic               free_s;
  logic               push_s;
  logic               xfer_s;
  logic               pop_s;

  assign free_s = (count_s != 2'd2);
  assign push_s = i_valid && free_s;
  assign xfer_s = (state_q == ST_SEND) && o_ready;
  assign pop_s  = xfer_s && (idx_q == LAST_IDX);

  bin_ser_fifo #(.BIN_W(BIN_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .din_i    (bin),
    .rd_idx_i (idx_q),
    .head_o   (head_s),
    .count_o  (count_s)
  );

  // FSM, bin index and sticky overflow next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (i_valid && !free_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (push_s) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Last histogram leaving with nothing arriving behind it
        if (pop_s && (count_s == 2'd1) && !push_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (xfer_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // FSM, bin index and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign i_ready = free_s;
  assign o_valid = (state_q == ST_SEND);
  assign o_idx   = idx_q;
  assign o_last  = (idx_q == LAST_IDX);
  assign o_bin   = o_valid ? head_s : {BIN_W{1'b0}};
  assign ovf     = ovf_q;

endmodule

// File: doc/bin_ser.md
BIN_SER -- requirements
Module: bin_ser

Interface
REQ-001 SHALL have parameter BIN_I, default 16, integer bits per bin.
REQ-002 SHALL have parameter MAG_F, default 4, fractional bits per bin; BIN_W = BIN_I + MAG_F (20) is derived and not overridable.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  packed histogram on bin is valid this cycle.
REQ-006 SHALL have port bin  input  BIN_W*9  packed histogram, bin 0 in LSBs, bin 8 in MSBs.
REQ-007 SHALL have port i_ready  output  1  high when at least one buffer entry is free.
REQ-008 SHALL have port o_valid  output  1  o_bin/o_idx/o_last valid.
REQ-009 SHALL have port o_ready  input  1  downstream accepts the current word.
REQ-010 SHALL have port o_bin  output  BIN_W  current bin value.
REQ-011 SHALL have port o_idx  output  4  current bin index, 0..8.
REQ-012 SHALL have port o_last  output  1  high when o_idx == 8.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag: a histogram was dropped.

Function
REQ-014 SHALL hold two histogram entries (9 x BIN_W each) as a FIFO with a 2-bit occupancy count (0..2).
REQ-015 SHALL push bin into the tail entry on the rising edge where i_valid=1 and count<2; push is independent of i_ready wiring upstream.
REQ-016 SHALL drive i_ready = (count<2) from registered state only, with no combinational path from i_valid or o_ready.
REQ-017 SHALL drop the vector and set ovf=1 on i_valid=1 with count==2, even if a pop completes in the same cycle; ovf clears only on reset.
REQ-018 SHALL use FSM states IDLE (count==0, o_valid=0) and SEND (o_valid=1).
REQ-019 SHALL transition IDLE->SEND on the edge after a push, giving o_valid=1, o_idx=0 and o_bin=bin[0] on the cycle after the push cycle (1-cycle latency).
REQ-020 SHALL transfer a word when o_valid && o_ready, then advance o_idx by 1 on the next edge; o_bin = head entry slice [o_idx].
REQ-021 SHALL hold o_bin, o_idx and o_last stable while o_valid=1 and o_ready=0.
REQ-022 SHALL, on transfer with o_idx==8: pop the head, reset o_idx to 0, and stay in SEND if count after pop is >0 (no bubble between histograms), else go to IDLE.
REQ-023 SHALL, on a simultaneous push and final-word pop with count==1, leave count at 1 and continue in SEND with the new entry at idx 0.
REQ-024 SHALL never reorder histograms or emit partial histograms; output order is bin 0..8 per histogram, FIFO order across histograms.
REQ-025 SHALL not perform arithmetic on bin values; widths pass through unchanged.

Reset
REQ-026 SHALL, on rst=1, immediately set count=0, o_idx=0, FSM=IDLE, o_valid=0, o_last=0, ovf=0 and i_ready=1; o_bin reads 0.
REQ-027 SHALL discard any histogram in flight when reset asserts mid-stream; no word is emitted after reset until a new push.
REQ-028 SHALL not require entry storage to be reset; entry contents are don't-care until written.

Structure
REQ-029 SHALL take BIN_W derivation and the bin count (9) from the shared HOG package also used by the histogram producer.
REQ-030 SHALL place the 2-entry storage and its pointers in one sub-module, bin_ser_fifo; the FSM and index counter stay in bin_ser.

Verification
REQ-031 SHALL cover single push of bins 0..8 = 1..9 with o_ready=1 -> o_valid first on cycle after push, words 1..9 on consecutive cycles, o_last only on value 9, then o_valid=0.
REQ-032 SHALL cover o_ready toggling 1,0,1,0 during a stream -> each word held while o_ready=0, no duplicates, no skips.
REQ-033 SHALL cover two pushes 1 cycle apart with o_ready=1 -> 18 back-to-back words in order, o_last on words 9 and 18.
REQ-034 SHALL cover three pushes with o_ready=0 -> i_ready=0 after the 2nd push, 3rd dropped, ovf=1; first two histograms later emitted intact.
REQ-035 SHALL cover rst asserted at o_idx=4 -> o_valid=0 and i_ready=1 the same cycle; the next push restarts at idx 0.
